// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for the N x N systolic matmul array: BRAM reads, skewed enables, capture.
// Optional SYS_CTRL_PERF_EN adds a perf_cycles run-length counter.
module systolic_ctrl #(
  parameter int N      = 4,
  parameter int ADDRW  = 9,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADDRW-1:0] base_a,
  input  logic [ADDRW-1:0] base_b,
  output logic             rd_en,
  output logic [ADDRW-1:0] a_addr,
  output logic [ADDRW-1:0] b_addr,
  output logic             acc_clr,
  output logic [N-1:0]     row_en,
  output logic [N-1:0]     col_en,
  output logic             capture,
  output logic             busy,
`ifdef SYS_CTRL_PERF_EN
  output logic [15:0]      perf_cycles,
`endif
  output logic             done
);

  localparam int LAST = RD_LAT + 2*N - 2;
  localparam int CW   = $clog2(LAST + 2);
  localparam logic [CW-1:0] LAST_C = CW'(LAST);
  localparam logic [CW-1:0] N_C    = CW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPT,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           rd_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      S_CLEAR: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
      S_RUN: begin
        if (cnt == LAST_C) begin
          state_nx = S_CAPT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_CAPT:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    // abort overrides everything, including a start seen in the same cycle
    if (abort) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
  end

  assign rd_nx = (state_nx == S_RUN) && (cnt_nx < N_C);

  // Addresses are registered so base_a/base_b never reach the outputs combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      a_addr <= rd_nx ? base_a + ADDRW'(cnt_nx) : '0;
      b_addr <= rd_nx ? base_b + ADDRW'(cnt_nx) : '0;
    end
  end

  assign rd_en   = (state == S_RUN) && (cnt < N_C);
  assign acc_clr = (state == S_CLEAR);
  assign capture = (state == S_CAPT);
  assign busy    = (state == S_CLEAR) || (state == S_RUN) || (state == S_CAPT);
  assign done    = (state == S_DONE);

  for (genvar i = 0; i < N; i++) begin : g_en
    localparam logic [CW-1:0] LO = CW'(RD_LAT + i);
    localparam logic [CW-1:0] HI = CW'(RD_LAT + i + N);
    assign row_en[i] = (state == S_RUN) && (cnt >= LO) && (cnt < HI);
    assign col_en[i] = row_en[i];
  end

`ifdef SYS_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (abort) begin
      perf_q <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      perf_q <= '0;
    end else if (busy && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed bench for systolic_ctrl at RD_LAT=1 and RD_LAT=3 against a run-position model.
module tb_systolic_ctrl;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [8:0] base_a;
  logic [8:0] base_b;

  logic       rd_en1, acc_clr1, capture1, busy1, done1;
  logic [8:0] a_addr1, b_addr1;
  logic [3:0] row_en1, col_en1;
  logic       rd_en3, acc_clr3, capture3, busy3, done3;
  logic [8:0] a_addr3, b_addr3;
  logic [3:0] row_en3, col_en3;
`ifdef SYS_CTRL_PERF_EN
  logic [15:0] perf1, perf3;
`endif

  systolic_ctrl #(.N(N), .ADDRW(9), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b),
    .rd_en(rd_en1), .a_addr(a_addr1), .b_addr(b_addr1), .acc_clr(acc_clr1),
    .row_en(row_en1), .col_en(col_en1), .capture(capture1), .busy(busy1),
`ifdef SYS_CTRL_PERF_EN
    .perf_cycles(perf1),
`endif
    .done(done1)
  );

  systolic_ctrl #(.N(N), .ADDRW(9), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b),
    .rd_en(rd_en3), .a_addr(a_addr3), .b_addr(b_addr3), .acc_clr(acc_clr3),
    .row_en(row_en3), .col_en(col_en3), .capture(capture3), .busy(busy3),
`ifdef SYS_CTRL_PERF_EN
    .perf_cycles(perf3),
`endif
    .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // model: pos = edges since the accepting edge while a run is in flight
  int lat_m [2];
  bit busy_m [2];
  int pos_m [2];
  bit done_m [2];
`ifdef SYS_CTRL_PERF_EN
  int perf_m [2];
`endif

  initial begin
    lat_m[0] = 1;
    lat_m[1] = 3;
  end

  always @(posedge clk or negedge reset) begin
    for (int id = 0; id < 2; id++) begin
      if (!reset) begin
        busy_m[id] <= 1'b0;
        pos_m[id]  <= 0;
        done_m[id] <= 1'b0;
`ifdef SYS_CTRL_PERF_EN
        perf_m[id] <= 0;
`endif
      end else if (!busy_m[id]) begin
        if (abort) begin
          done_m[id] <= 1'b0;
`ifdef SYS_CTRL_PERF_EN
          perf_m[id] <= 0;
`endif
        end else if (start) begin
          busy_m[id] <= 1'b1;
          pos_m[id]  <= 0;
          done_m[id] <= 1'b0;
`ifdef SYS_CTRL_PERF_EN
          perf_m[id] <= 0;
`endif
        end
      end else if (abort) begin
        busy_m[id] <= 1'b0;
`ifdef SYS_CTRL_PERF_EN
        perf_m[id] <= 0;
`endif
      end else begin
        pos_m[id] <= pos_m[id] + 1;
`ifdef SYS_CTRL_PERF_EN
        perf_m[id] <= (perf_m[id] < 65535) ? perf_m[id] + 1 : 65535;
`endif
        if (pos_m[id] + 1 == lat_m[id] + 2*N + 1) begin
          busy_m[id] <= 1'b0;
          done_m[id] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [30:0] exp_vec(input int id);
    int         lat;
    int         last;
    int         p;
    int         c;
    logic       run;
    logic       rd;
    logic [8:0] aa;
    logic [8:0] bb;
    logic [3:0] en;
    logic       clr;
    logic       cap;
    lat  = lat_m[id];
    last = lat + 2*N - 2;
    p    = pos_m[id];
    c    = p - 1;
    run  = busy_m[id] && p >= 1 && p <= last + 1;
    rd   = run && c < N;
    aa   = rd ? 9'(int'(base_a) + c) : 9'd0;
    bb   = rd ? 9'(int'(base_b) + c) : 9'd0;
    for (int i = 0; i < N; i++) en[i] = run && c >= lat + i && c < lat + i + N;
    clr = busy_m[id] && p == 0;
    cap = busy_m[id] && p == last + 2;
    return {rd, aa, bb, clr, en, en, cap, busy_m[id], done_m[id]};
  endfunction

  logic [30:0] act1, act3;
  assign act1 = {rd_en1, a_addr1, b_addr1, acc_clr1, row_en1, col_en1, capture1, busy1, done1};
  assign act3 = {rd_en3, a_addr3, b_addr3, acc_clr3, row_en3, col_en3, capture3, busy3, done3};

  task automatic compare_all();
    logic [30:0] e1;
    logic [30:0] e3;
    e1 = exp_vec(0);
    e3 = exp_vec(1);
    total++;
    if (act1 !== e1) begin
      bad++;
      $display("FAIL model_lat1 t=%0t act=%h req=%h", $time, act1, e1);
    end
    total++;
    if (act3 !== e3) begin
      bad++;
      $display("FAIL model_lat3 t=%0t act=%h req=%h", $time, act3, e3);
    end
`ifdef SYS_CTRL_PERF_EN
    total++;
    if (perf1 !== 16'(perf_m[0]) || perf3 !== 16'(perf_m[1])) begin
      bad++;
      $display("FAIL model_perf t=%0t act=%0d/%0d req=%0d/%0d", $time, perf1, perf3, perf_m[0], perf_m[1]);
    end
`endif
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  int seen;

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    base_a = 9'd0;
    base_b = 9'd16;
    #1;
    chk("reset_vec1", int'(act1), 0);
    chk("reset_vec3", int'(act3), 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_busy", int'(busy1), 0);

    // nominal run; cycle 0 is the one where start is seen
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      if (k == 1) chk("nom_acc_clr", int'(acc_clr1), 1);
      if (k == 2) chk("nom_rd0", int'({rd_en1, a_addr1, b_addr1}), (1 << 18) | 16);
      if (k == 3) chk("nom_row_cnt1", int'(row_en1), 4'b0001);
      if (k == 5) chk("nom_rd3", int'({rd_en1, a_addr1, b_addr1}), (1 << 18) | (3 << 9) | 19);
      if (k == 6) chk("nom_rd_off", int'({rd_en1, a_addr1}), 0);
      if (k == 6) chk("nom_row_cnt4", int'(row_en1), 4'b1111);
      if (k == 9) chk("nom_row_cnt7", int'(row_en1), 4'b1000);
      if (k == 10) chk("nom_capture", int'(capture1), 1);
      if (k == 11) chk("nom_done", int'({done1, busy1}), 2);
      if (k == 4) chk("lat3_row_cnt2", int'(row_en3), 0);
      if (k == 5) chk("lat3_row_cnt3", int'(row_en3), 4'b0001);
      if (k == 12) chk("lat3_capture", int'(capture3), 1);
      if (k == 13) chk("lat3_done", int'(done3), 1);
`ifdef SYS_CTRL_PERF_EN
      if (k == 13) chk("perf_lat1", int'(perf1), 10);
      if (k == 13) chk("perf_lat3", int'(perf3), 12);
`endif
    end

    // start held high through the whole run, from DONE
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) chk("held_done_drop", int'({done1, acc_clr1}), 1);
      if (k == 5) chk("held_no_reaccept", int'({acc_clr1, busy1}), 1);
      if (k == 11) chk("held_done", int'(done1), 1);
      if (k == 12) chk("held_restart", int'({done1, acc_clr1}), 1);
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("held_abort_idle", int'({busy1, busy3, done1, done3}), 0);

    // abort wins over simultaneous start
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins", int'({busy1, acc_clr1}), 0);

    // abort at cnt=3
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      start = 1'b0;
    end
    chk("abort_pre_rd", int'(rd_en1), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outs", int'({rd_en1, row_en1, busy1, a_addr1}), 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (capture1 || done1 || capture3 || done3) seen++;
    end
    chk("abort_no_capture_done", seen, 0);

    // address wrap
    base_a = 9'd510;
    start  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      start = 1'b0;
      if (k == 2) chk("wrap_a0", int'(a_addr1), 510);
      if (k == 3) chk("wrap_a1", int'(a_addr1), 511);
      if (k == 4) chk("wrap_a2", int'(a_addr1), 0);
      if (k == 5) chk("wrap_a3", int'(a_addr1), 1);
    end

    // reset mid-run
    base_a = 9'd0;
    start  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
    end
    chk("rst_pre_busy", int'(busy1), 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_vec1", int'(act1), 0);
    chk("rst_mid_vec3", int'(act3), 0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("rst_after_idle", int'({busy1, done1, busy3, done3}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
